// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Program counter and fetch controller for a synchronous-read instruction
// memory with one-cycle read latency. Tracks which PC each returned word
// belongs to, holds the presented word under stall, redirects on taken
// branches, and keeps a saturating count of accepted instructions.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start, start_addr   begin fetching at start_addr (sampled in IDLE only)
//   halt                stop fetching, return to IDLE
//   stall               downstream cannot accept the presented word
//   branch_taken/target redirect fetch
//   imem_addr/imem_data instruction memory address out / registered data in
//   instr, instr_pc     presented word and its PC
//   instr_valid         instr/instr_pc valid this cycle
//   busy                not IDLE
//   fetch_count         saturating accepted-instruction count
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | not fetching; waits for start
// FILL  | memory is latching data[pc]; nothing presented yet
// RUN   | word for f_pc is on imem_data and presented downstream

module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              halt,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] f_pc, f_pc_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              hold_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      f_pc  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      f_pc  <= f_pc_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    f_pc_next  = f_pc;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          pc_next    = start_addr;
          cnt_next   = '0;
          state_next = FILL;
        end
      end
      FILL: begin
        if (halt) begin
          state_next = IDLE;
        end else if (branch_taken) begin
          pc_next = branch_target;
        end else begin
          f_pc_next  = pc;
          pc_next    = pc + PC_ONE;
          state_next = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          state_next = IDLE;
        end else if (branch_taken) begin
          pc_next    = branch_target;
          state_next = FILL;
        end else if (!stall) begin
          f_pc_next = pc;
          pc_next   = pc + PC_ONE;
          if (cnt != CNT_MAX) cnt_next = cnt + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Under a plain stall the memory re-reads the presented word so imem_data
  // stays stable; any higher-priority event needs the new pc instead.
  assign hold_addr = (state == RUN) && stall && !branch_taken && !halt;

  // Outputs are forced to their reset values while reset is asserted, not
  // only after the reset edge.
  assign imem_addr   = reset ? '0 : (hold_addr ? f_pc : pc);
  assign instr       = imem_data;
  assign instr_pc    = reset ? '0 : f_pc;
  assign instr_valid = !reset && (state == RUN);
  assign busy        = !reset && (state != IDLE);
  assign fetch_count = cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  start_addr;
  logic        halt;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        busy;
  logic [15:0] fetch_count;

  // second instance with a narrow counter to reach saturation quickly
  logic [7:0]  imem_addr_s;
  logic [31:0] instr_s;
  logic [7:0]  instr_pc_s;
  logic        instr_valid_s;
  logic        busy_s;
  logic [3:0]  fetch_count_s;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  // reference model (transaction view: active / filling / current and next pc)
  bit m_active, m_fill;
  int m_pc, m_cur, m_cnt, m_cnt_s;

  fetch_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .halt(halt), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .busy(busy), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .halt(halt), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr_s),
    .imem_data(imem_data), .instr(instr_s), .instr_pc(instr_pc_s),
    .instr_valid(instr_valid_s), .busy(busy_s), .fetch_count(fetch_count_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) imem_data <= mem[imem_addr];

  function automatic logic [7:0] exp_addr();
    if (reset) return 8'd0;
    if (m_active && !m_fill && stall && !branch_taken && !halt) return m_cur[7:0];
    return m_pc[7:0];
  endfunction

  function automatic logic exp_valid();
    return !reset && m_active && !m_fill;
  endfunction

  function automatic logic exp_busy();
    return !reset && m_active;
  endfunction

  function automatic logic [7:0] exp_pc();
    return reset ? 8'd0 : m_cur[7:0];
  endfunction

  task automatic drive(input logic r, input logic s, input logic [7:0] sa,
                       input logic h, input logic st, input logic b,
                       input logic [7:0] bt);
    reset = r; start = s; start_addr = sa; halt = h; stall = st;
    branch_taken = b; branch_target = bt;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m_active = 0; m_fill = 0; m_pc = 0; m_cur = 0; m_cnt = 0; m_cnt_s = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_fill = 1; m_pc = start_addr; m_cnt = 0; m_cnt_s = 0;
      end
    end else if (halt) begin
      m_active = 0; m_fill = 0;
    end else if (branch_taken) begin
      m_pc = branch_target; m_fill = 1;
    end else if (m_fill) begin
      m_cur = m_pc; m_pc = (m_pc + 1) % 256; m_fill = 0;
    end else if (!stall) begin
      m_cur = m_pc; m_pc = (m_pc + 1) % 256;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 15) m_cnt_s++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
    tick(); tick();
    idle_inputs();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %0h want 0", imem_addr); end
    checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %0h want 0", instr_pc); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
  endtask

  task automatic test_sequential();
    drive(0, 1, 8'h00, 0, 0, 0, 8'h00);
    tick();
    idle_inputs();
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_fill got busy=%0b valid=%0b want 1/0", busy, instr_valid); end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid k=%0d got %0b want 1", k, instr_valid); end
      checks++; if (instr_pc !== 8'(k)) begin errors++; $display("FAIL seq_pc got %0h want %0h", instr_pc, k); end
      checks++; if (instr !== 32'h100 + 32'(k)) begin errors++; $display("FAIL seq_instr got %0h want %0h", instr, 32'h100 + k); end
      tick();
    end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL seq_count3 got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 0, 1, 0, 8'h00);
      checks++; if (imem_addr !== 8'h03) begin errors++; $display("FAIL stall_addr got %0h want 03", imem_addr); end
      tick();
      checks++; if (instr_pc !== 8'h03 || instr !== 32'h103 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got pc=%0h instr=%0h valid=%0b want 03/103/1", instr_pc, instr, instr_valid); end
      checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL stall_count got %0d want 3", fetch_count); end
    end
    idle_inputs();
    tick();
    checks++; if (instr_pc !== 8'h04 || instr !== 32'h104) begin errors++; $display("FAIL stall_release got pc=%0h instr=%0h want 04/104", instr_pc, instr); end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL seq_count4 got %0d want 4", fetch_count); end
  endtask

  task automatic test_branch();
    tick();
    checks++; if (instr_pc !== 8'h05) begin errors++; $display("FAIL br_pre got %0h want 05", instr_pc); end
    drive(0, 0, 8'h00, 0, 1, 1, 8'h25);
    checks++; if (imem_addr !== 8'h06) begin errors++; $display("FAIL br_addr got %0h want 06", imem_addr); end
    tick();
    idle_inputs();
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL br_bubble got valid=%0b busy=%0b want 0/1", instr_valid, busy); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h25 || instr !== 32'h125) begin errors++; $display("FAIL br_target got valid=%0b pc=%0h instr=%0h want 1/25/125", instr_valid, instr_pc, instr); end
    checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL br_count got %0d want 5", fetch_count); end
  endtask

  task automatic test_halt();
    drive(0, 0, 8'h00, 1, 0, 0, 8'h00);
    tick();
    idle_inputs();
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_idle got busy=%0b valid=%0b want 0/0", busy, instr_valid); end
    drive(0, 1, 8'h10, 0, 0, 0, 8'h00);
    tick();
    idle_inputs();
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h10 || instr !== 32'h110) begin errors++; $display("FAIL restart got valid=%0b pc=%0h instr=%0h want 1/10/110", instr_valid, instr_pc, instr); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL restart_count got %0d want 0", fetch_count); end
  endtask

  task automatic test_wrap();
    logic [7:0] want [4];
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    drive(0, 0, 8'h00, 1, 0, 0, 8'h00);
    tick();
    drive(0, 1, 8'hFE, 0, 0, 0, 8'h00);
    tick();
    idle_inputs();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_pc !== want[i] || instr !== 32'h100 + 32'(want[i])) begin errors++; $display("FAIL wrap_%0d got valid=%0b pc=%0h instr=%0h want 1/%0h", i, instr_valid, instr_pc, instr, want[i]); end
      tick();
    end
  endtask

  task automatic test_reset_in_stall();
    drive(0, 0, 8'h00, 0, 1, 0, 8'h00);
    tick();
    drive(1, 0, 8'h00, 0, 1, 0, 8'h00);
    tick();
    drive(0, 0, 8'h00, 0, 1, 0, 8'h00);
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h00 || instr_pc !== 8'h00 || fetch_count !== 16'd0) begin
      errors++; $display("FAIL rst_stall got valid=%0b busy=%0b addr=%0h pc=%0h cnt=%0d want all 0", instr_valid, busy, imem_addr, instr_pc, fetch_count);
    end
  endtask

  task automatic test_saturation();
    drive(0, 1, 8'h40, 0, 0, 0, 8'h00);
    tick();
    idle_inputs();
    tick();
    for (int n = 0; n < 18; n++) begin
      tick();
      checks++; if (fetch_count_s !== 4'(m_cnt_s) || m_cnt_s != ((n + 1 > 15) ? 15 : n + 1)) begin
        errors++; $display("FAIL sat_%0d got %0d want %0d", n, fetch_count_s, (n + 1 > 15) ? 15 : n + 1);
      end
    end
    checks++; if (fetch_count !== 16'd18) begin errors++; $display("FAIL sat_wide got %0d want 18", fetch_count); end
  endtask

  task automatic test_random();
    drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25), 8'($urandom),
            ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 10), 8'($urandom));
      checks++; if (imem_addr !== exp_addr() || imem_addr_s !== exp_addr()) begin errors++; $display("FAIL rnd_addr c=%0d got %0h want %0h", c, imem_addr, exp_addr()); end
      checks++; if (instr_valid !== exp_valid() || instr_valid_s !== exp_valid()) begin errors++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, instr_valid, exp_valid()); end
      checks++; if (busy !== exp_busy() || busy_s !== exp_busy()) begin errors++; $display("FAIL rnd_busy c=%0d got %0b want %0b", c, busy, exp_busy()); end
      checks++; if (instr_pc !== exp_pc() || instr_pc_s !== exp_pc()) begin errors++; $display("FAIL rnd_pc c=%0d got %0h want %0h", c, instr_pc, exp_pc()); end
      checks++; if (fetch_count !== 16'(m_cnt) || fetch_count_s !== 4'(m_cnt_s)) begin errors++; $display("FAIL rnd_count c=%0d got %0d/%0d want %0d/%0d", c, fetch_count, fetch_count_s, m_cnt, m_cnt_s); end
      if (exp_valid()) begin
        checks++; if (instr !== mem[m_cur] || instr_s !== mem[m_cur]) begin errors++; $display("FAIL rnd_instr c=%0d got %0h want %0h", c, instr, mem[m_cur]); end
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h100 + 32'(k);
    m_active = 0; m_fill = 0; m_pc = 0; m_cur = 0; m_cnt = 0; m_cnt_s = 0;
    drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
    @(negedge clock);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_in_stall();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
